// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle ALU; define SEQ_ALU_DIV_EN to build in the restoring divider (op 9)
module seq_alu #(
    parameter int WIDTH = 4,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans,
    output logic [WIDTH-1:0] hi,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] b_r, res_ans, res_hi;
    logic [SHW-1:0] cnt;
    logic [2*WIDTH-1:0] p, p_nx;
    logic [WIDTH:0] sum, dif, macc;
    logic res_err, iter, accept, last;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign accept = in_valid && in_ready;
    assign last = state == CALC && cnt == '0;
`ifdef SEQ_ALU_DIV_EN
    assign iter = op == 4'd8 || (op == 4'd9 && inB != '0);
`else
    assign iter = op == 4'd8;
`endif
    always_comb begin
        sum = {1'b0, inA} + {1'b0, inB};
        dif = {1'b0, inA} - {1'b0, inB};
        res_ans = '0;
        res_hi = '0;
        res_err = 1'b0;
        case (op)
            4'd0: begin res_ans = sum[WIDTH-1:0]; res_hi = WIDTH'(sum[WIDTH]); end
            4'd1: begin res_ans = dif[WIDTH-1:0]; res_hi = WIDTH'(dif[WIDTH]); end
            4'd2: res_ans = inA & inB;
            4'd3: res_ans = inA | inB;
            4'd4: res_ans = inA ^ inB;
            4'd5: res_ans = WIDTH'($signed(inA) < $signed(inB));
            4'd6: res_ans = inA << inB[SHW-1:0];
            4'd7: res_ans = inA >> inB[SHW-1:0];
            4'd8: res_ans = '0;
`ifdef SEQ_ALU_DIV_EN
            // Only the divide-by-zero outcome is decided here; B!=0 iterates.
            4'd9: if (inB == '0) begin res_ans = '1; res_hi = inA; res_err = 1'b1; end
`endif
            default: res_err = 1'b1;
        endcase
    end
`ifdef SEQ_ALU_DIV_EN
    logic mul_r;
    logic [WIDTH:0] rem, rdif;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mul_r <= 1'b0;
        else if (accept) mul_r <= op == 4'd8;
    // p holds {acc, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        macc = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_r} : '0);
        rem = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        rdif = rem - {1'b0, b_r};
        p_nx = mul_r ? {macc, p[WIDTH-1:1]}
                     : {rem >= {1'b0, b_r} ? rdif[WIDTH-1:0] : rem[WIDTH-1:0], p[WIDTH-2:0], rem >= {1'b0, b_r}};
    end
`else
    always_comb begin
        macc = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_r} : '0);
        p_nx = {macc, p[WIDTH-1:1]};
    end
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = iter ? CALC : DONE;
            CALC: if (cnt == '0) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            ans <= '0;
            hi <= '0;
            err <= 1'b0;
            b_r <= '0;
            p <= '0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                b_r <= inB;
                p <= {{WIDTH{1'b0}}, inA};
                cnt <= SHW'(WIDTH - 1);
            end else if (state == CALC) begin
                p <= p_nx;
                cnt <= cnt - SHW'(1);
            end
            if (accept && !iter) begin
                ans <= res_ans;
                hi <= res_hi;
                err <= res_err;
            end else if (last) begin
                ans <= p_nx[WIDTH-1:0];
                hi <= p_nx[2*WIDTH-1:WIDTH];
                err <= 1'b0;
            end
        end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu at WIDTH=4
module tb_seq_alu;
    localparam int W = 4;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, err;
    logic [W-1:0] inA = '0, inB = '0, ans, hi;
    logic [3:0] op = '0;
    int checks = 0, errors = 0;
    int lat;
    logic rdy_seen;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inA(inA), .inB(inB), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .ans(ans), .hi(hi), .err(err)
    );

    always #5 clk = ~clk;

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] o);
        int w = 0;
        @(negedge clk);
        inA = a; inB = b; op = o; in_valid = 1'b1;
        while (!in_ready && w < 16) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        in_valid = 1'b0; inA = ~a; inB = ~b; op = 4'd0;
        lat = 1;
        rdy_seen = in_ready;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            rdy_seen |= in_ready;
        end
    endtask

    task automatic consume();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (ans !== 4'h0) begin errors++; $display("FAIL rst_ans: got %h want 0", ans); end
        checks++; if (hi !== 4'h0) begin errors++; $display("FAIL rst_hi: got %h want 0", hi); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_addsub();
        run(4'h6, 4'h5, 4'd0);
        checks++; if (lat != 1) begin errors++; $display("FAIL add_lat: got %0d want 1", lat); end
        checks++; if (ans !== 4'hB || hi !== 4'h0 || err !== 1'b0) begin errors++; $display("FAIL add: got %h/%h/%b want b/0/0", ans, hi, err); end
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_release: got ov=%b ir=%b want 0/1", out_valid, in_ready); end
        run(4'hF, 4'h1, 4'd0);
        checks++; if (ans !== 4'h0 || hi !== 4'h1) begin errors++; $display("FAIL add_carry: got %h/%h want 0/1", ans, hi); end
        consume();
        run(4'h6, 4'h5, 4'd1);
        checks++; if (ans !== 4'h1 || hi !== 4'h0 || err !== 1'b0) begin errors++; $display("FAIL sub: got %h/%h/%b want 1/0/0", ans, hi, err); end
        consume();
        run(4'h5, 4'h6, 4'd1);
        checks++; if (ans !== 4'hF || hi !== 4'h1) begin errors++; $display("FAIL sub_borrow: got %h/%h want f/1", ans, hi); end
        consume();
    endtask

    task automatic test_logic();
        run(4'h6, 4'h5, 4'd2);
        checks++; if (ans !== 4'h4 || hi !== 4'h0) begin errors++; $display("FAIL and: got %h/%h want 4/0", ans, hi); end
        consume();
        run(4'h6, 4'h5, 4'd3);
        checks++; if (ans !== 4'h7) begin errors++; $display("FAIL or: got %h want 7", ans); end
        consume();
        run(4'h6, 4'h5, 4'd4);
        checks++; if (ans !== 4'h3) begin errors++; $display("FAIL xor: got %h want 3", ans); end
        consume();
        run(4'h6, 4'h5, 4'd6);
        checks++; if (ans !== 4'hC || hi !== 4'h0) begin errors++; $display("FAIL sll: got %h/%h want c/0", ans, hi); end
        consume();
        run(4'h6, 4'h5, 4'd7);
        checks++; if (ans !== 4'h3) begin errors++; $display("FAIL srl: got %h want 3", ans); end
        consume();
        run(4'hF, 4'h1, 4'd5);
        checks++; if (ans !== 4'h1 || err !== 1'b0) begin errors++; $display("FAIL slt_true: got %h/%b want 1/0", ans, err); end
        consume();
        run(4'h1, 4'hF, 4'd5);
        checks++; if (ans !== 4'h0) begin errors++; $display("FAIL slt_false: got %h want 0", ans); end
        consume();
    endtask

    task automatic test_mul();
        run(4'h6, 4'h5, 4'd8);
        checks++; if (lat != 5) begin errors++; $display("FAIL mul_lat: got %0d want 5", lat); end
        checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL mul_in_ready: got %b want 0", rdy_seen); end
        checks++; if (ans !== 4'hE || hi !== 4'h1 || err !== 1'b0) begin errors++; $display("FAIL mul: got %h/%h/%b want e/1/0", ans, hi, err); end
        consume();
        run(4'hF, 4'hF, 4'd8);
        checks++; if (ans !== 4'h1 || hi !== 4'hE) begin errors++; $display("FAIL mul_max: got %h/%h want 1/e", ans, hi); end
        consume();
    endtask

    task automatic test_div();
`ifdef SEQ_ALU_DIV_EN
        run(4'h6, 4'h5, 4'd9);
        checks++; if (lat != 5) begin errors++; $display("FAIL div_lat: got %0d want 5", lat); end
        checks++; if (ans !== 4'h1 || hi !== 4'h1 || err !== 1'b0) begin errors++; $display("FAIL div: got %h/%h/%b want 1/1/0", ans, hi, err); end
        consume();
        run(4'hD, 4'h3, 4'd9);
        checks++; if (ans !== 4'h4 || hi !== 4'h1) begin errors++; $display("FAIL div_13_3: got %h/%h want 4/1", ans, hi); end
        consume();
        run(4'h6, 4'h0, 4'd9);
        checks++; if (lat != 1) begin errors++; $display("FAIL div0_lat: got %0d want 1", lat); end
        checks++; if (ans !== 4'hF || hi !== 4'h6 || err !== 1'b1) begin errors++; $display("FAIL div0: got %h/%h/%b want f/6/1", ans, hi, err); end
        consume();
`else
        run(4'h6, 4'h5, 4'd9);
        checks++; if (lat != 1) begin errors++; $display("FAIL nodiv_lat: got %0d want 1", lat); end
        checks++; if (ans !== 4'h0 || hi !== 4'h0 || err !== 1'b1) begin errors++; $display("FAIL nodiv: got %h/%h/%b want 0/0/1", ans, hi, err); end
        consume();
`endif
    endtask

    task automatic test_backpressure();
        run(4'h6, 4'h5, 4'd12);
        checks++; if (lat != 1) begin errors++; $display("FAIL ill_lat: got %0d want 1", lat); end
        checks++; if (ans !== 4'h0 || hi !== 4'h0 || err !== 1'b1) begin errors++; $display("FAIL ill: got %h/%h/%b want 0/0/1", ans, hi, err); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || ans !== 4'h0 || hi !== 4'h0 || err !== 1'b1) begin
                errors++; $display("FAIL hold%0d: got ov=%b ir=%b %h/%h/%b want 1/0 0/0/1", i, out_valid, in_ready, ans, hi, err);
            end
        end
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL hold_release: got ov=%b ir=%b err=%b want 0/1/1", out_valid, in_ready, err); end
    endtask

    task automatic test_reset_mid_mul();
        run(4'h6, 4'h5, 4'd0);
        consume();
        @(negedge clk); inA = 4'h6; inB = 4'h5; op = 4'd8; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_hs: got ov=%b ir=%b want 0/1", out_valid, in_ready); end
        checks++; if (ans !== 4'h0 || hi !== 4'h0 || err !== 1'b0) begin errors++; $display("FAIL midrst_out: got %h/%h/%b want 0/0/0", ans, hi, err); end
        @(negedge clk); rst_n = 1'b1;
        run(4'h6, 4'h5, 4'd0);
        checks++; if (lat != 1 || ans !== 4'hB || hi !== 4'h0) begin errors++; $display("FAIL midrst_add: got lat=%0d %h/%h want 1 b/0", lat, ans, hi); end
        consume();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        run(4'h3, 4'h4, 4'd0);
        checks++; if (ans !== 4'h7 || lat != 1) begin errors++; $display("FAIL b2b_add: got %h lat=%0d want 7 lat=1", ans, lat); end
        run(4'h9, 4'h3, 4'd2);
        checks++; if (ans !== 4'h1 || lat != 1) begin errors++; $display("FAIL b2b_and: got %h lat=%0d want 1 lat=1", ans, lat); end
        run(4'h3, 4'h3, 4'd8);
        checks++; if (ans !== 4'h9 || hi !== 4'h0 || lat != 5) begin errors++; $display("FAIL b2b_mul: got %h/%h lat=%0d want 9/0 lat=5", ans, hi, lat); end
        out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_logic();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
